// File: rtl/axis_mem2m_pkg.sv
// Shared constants for the mem-to-master stream path: memory geometry,
// complex-sample field positions inside a result word, and TX state encodings.
package axis_mem2m_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 44;

    // A result word packs {re, im} as two 22-bit two's-complement fields
    localparam int RE_MSB = 43;
    localparam int RE_LSB = 22;
    localparam int IM_MSB = 21;
    localparam int IM_LSB = 0;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_STREAM = 2'd1,
        TX_DRAIN  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/axis_mem2m_bit_reverse.sv
// Pure combinational bit-order reversal, used to turn a linear beat index
// into the bit-reversed address of the matching FFT result.
module axis_mem2m_bit_reverse #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dout[i] = din[WIDTH-1-i];
        end
    end

endmodule

// File: rtl/axis_mem2m.sv
// Streams one FFT frame from result memory mem0 onto an AXI4-Stream master.
// Define AXIS_MEM2M_BITREV_EN to read in bit-reversed order (natural frequency output).
module axis_mem2m
    import axis_mem2m_pkg::*;
#(
    parameter int FFT_SIZE    = 4096,
    parameter int TDATA_WIDTH = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    axis_tx,
    output logic                    axis_mem2m_clken,
    output logic [ADDR_WIDTH-1:0]   axis_mem2m_raddr,
    input  logic [DATA_WIDTH-1:0]   axis_mem2m_rdata,
    output logic [TDATA_WIDTH-1:0]  m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast
);

    localparam int COMP_W = TDATA_WIDTH / 2;
    localparam int RE_W   = RE_MSB - RE_LSB + 1;
    localparam int IM_W   = IM_MSB - IM_LSB + 1;
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(FFT_SIZE - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    tx_state_t state;
    tx_state_t next_state;

    // One extra counter bit so a full 2^ADDR_WIDTH frame reaches its last index cleanly
    logic [ADDR_WIDTH:0] rd_cnt;
    logic                issue;
    logic                beat_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= TX_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Memory reads advance only when the output register is empty or being drained
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        beat_done  = 1'b0;
        case (state)
            TX_IDLE: begin
                if (start) begin
                    next_state = TX_STREAM;
                end
            end
            TX_STREAM: begin
                issue = ~m_axis_tvalid | m_axis_tready;
                if (issue && (rd_cnt == LAST_IDX)) begin
                    next_state = TX_DRAIN;
                end
            end
            TX_DRAIN: begin
                beat_done = m_axis_tvalid & m_axis_tready;
                if (beat_done) begin
                    next_state = TX_IDLE;
                end
            end
            default: next_state = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= beat_done;
            if ((state == TX_IDLE) && start) begin
                rd_cnt <= '0;
            end else if (issue) begin
                rd_cnt <= rd_cnt + CNT_ONE;
            end
            if (issue) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= (rd_cnt == LAST_IDX);
            end else if (beat_done) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
        end
    end

    assign busy             = (state != TX_IDLE);
    assign axis_tx          = busy;
    assign axis_mem2m_clken = issue;

    // Held read data doubles as the output register while stalled
    assign m_axis_tdata = {{(COMP_W - RE_W){axis_mem2m_rdata[RE_MSB]}}, axis_mem2m_rdata[RE_MSB:RE_LSB],
                           {(COMP_W - IM_W){axis_mem2m_rdata[IM_MSB]}}, axis_mem2m_rdata[IM_MSB:IM_LSB]};

`ifdef AXIS_MEM2M_BITREV_EN
    localparam int LOG2_SIZE = $clog2(FFT_SIZE);
    logic [LOG2_SIZE-1:0] rev_addr;

    axis_mem2m_bit_reverse #(
        .WIDTH (LOG2_SIZE)
    ) u_bit_reverse (
        .din  (rd_cnt[LOG2_SIZE-1:0]),
        .dout (rev_addr)
    );

    assign axis_mem2m_raddr = ADDR_WIDTH'(rev_addr);
`else
    assign axis_mem2m_raddr = rd_cnt[ADDR_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_axis_mem2m.sv
// Scoreboard bench for axis_mem2m at FFT_SIZE=16: randomized backpressure and
// memory contents, expected beats queued at each start and popped by a monitor.
module tb_axis_mem2m;
    import axis_mem2m_pkg::*;

    localparam int FFT  = 16;
    localparam int LOG2 = 4;
    localparam int TW   = 48;

    typedef struct packed {
        logic [TW-1:0] data;
        logic          last;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  axis_tx;
    logic                  clken;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic [TW-1:0]         tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    int    checks = 0;
    int    errors = 0;
    int    mem_re [FFT];
    int    mem_im [FFT];
    beat_t exp_q [$];
    int    ready_mode = 0;
    int    hold_cnt = 0;
    int    beats_seen = 0;
    int    done_count = 0;

    axis_mem2m #(
        .FFT_SIZE    (FFT),
        .TDATA_WIDTH (TW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .axis_tx          (axis_tx),
        .axis_mem2m_clken (clken),
        .axis_mem2m_raddr (raddr),
        .axis_mem2m_rdata (rdata),
        .m_axis_tdata     (tdata),
        .m_axis_tvalid    (tvalid),
        .m_axis_tready    (tready),
        .m_axis_tlast     (tlast)
    );

    always #5 clk = ~clk;

    function automatic int bitrev(input int k);
        int r = 0;
        for (int i = 0; i < LOG2; i++) begin
            r = r * 2 + ((k >> i) % 2);
        end
        return r;
    endfunction

    // Memory location holding the k-th beat of a frame
    function automatic int addrOf(input int k);
`ifdef AXIS_MEM2M_BITREV_EN
        return bitrev(k);
`else
        return k;
`endif
    endfunction

    function automatic logic [DATA_WIDTH-1:0] memWord(input int a);
        if (a >= FFT) return '0;
        return {22'(mem_re[a]), 22'(mem_im[a])};
    endfunction

    always @(posedge clk) begin
        if (clken) rdata <= memWord(int'(raddr));
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushFrame();
        beat_t e;
        for (int k = 0; k < FFT; k++) begin
            e.data = {24'(mem_re[addrOf(k)]), 24'(mem_im[addrOf(k)])};
            e.last = (k == FFT - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic fillRamp();
        for (int k = 0; k < FFT; k++) begin
            mem_re[k] = k;
            mem_im[k] = -k;
        end
    endtask

    task automatic fillRandom();
        for (int k = 0; k < FFT; k++) begin
            mem_re[k] = int'($urandom_range(0, 4194303)) - 2097152;
            mem_im[k] = int'($urandom_range(0, 4194303)) - 2097152;
        end
    endtask

    // Drives start high for the current cycle; caller is just after a rising edge
    task automatic pulseStartNow(input bit expect_frame);
        start = 1'b1;
        if (expect_frame) pushFrame();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic applyStimulus(input bit expect_frame);
        @(posedge clk);
        #1;
        pulseStartNow(expect_frame);
    endtask

    task automatic waitDone(input string name, input int budget);
        int d0 = done_count;
        int n = 0;
        while (done_count == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput(name, 64'(done_count - d0 > 0), 64'(1));
    endtask

    task automatic waitBeats(input int target, input int budget);
        int n = 0;
        while (beats_seen < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("beat_wait", 64'(beats_seen >= target), 64'(1));
    endtask

    // Downstream ready generator
    initial begin
        tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: tready = 1'($urandom_range(0, 1));
                2: begin
                    if (tvalid && tlast && hold_cnt < 5) begin
                        tready = 1'b0;
                        hold_cnt++;
                    end else begin
                        tready = 1'b1;
                    end
                end
                default: tready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pops, stall stability, done timing and read order
    initial begin
        beat_t prev_beat;
        beat_t e;
        bit    prev_stall = 0;
        bit    exp_done = 0;
        bit    prev_busy = 0;
        int    issue_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                exp_done = 0;
                prev_busy = 0;
                continue;
            end
            checkOutput("done", 64'(done), 64'(exp_done));
            if (done) done_count++;
            exp_done = 0;
            if (prev_stall) begin
                checkOutput("stall_valid", 64'(tvalid), 64'(1));
                checkOutput("stall_data", 64'(tdata), 64'(prev_beat.data));
                checkOutput("stall_last", 64'(tlast), 64'(prev_beat.last));
            end
            if (tvalid && !tready) checkOutput("stall_clken", 64'(clken), 64'(0));
            if (busy && !prev_busy) issue_cnt = 0;
            if (clken) begin
                checkOutput("raddr", 64'(raddr), 64'(addrOf(issue_cnt)));
                issue_cnt++;
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got tdata %h, expected no beat at %0t", tdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("tdata", 64'(tdata), 64'(e.data));
                    checkOutput("tlast", 64'(tlast), 64'(e.last));
                    if (e.last) exp_done = 1;
                end
                beats_seen++;
            end
            prev_stall = tvalid && !tready;
            prev_beat.data = tdata;
            prev_beat.last = tlast;
            prev_busy = busy;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dc0;
        int b0;
        rst = 1'b1;
        start = 1'b0;
        fillRamp();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_axis_tx", 64'(axis_tx), 64'(0));
        checkOutput("rst_clken", 64'(clken), 64'(0));
        checkOutput("rst_raddr", 64'(raddr), 64'(0));
        checkOutput("rst_tvalid", 64'(tvalid), 64'(0));
        checkOutput("rst_tlast", 64'(tlast), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] ramp frame, tready=1, latency check");
        ready_mode = 0;
        applyStimulus(1);
        @(negedge clk);
        checkOutput("lat_busy", 64'(busy), 64'(1));
        checkOutput("lat_axis_tx", 64'(axis_tx), 64'(1));
        checkOutput("lat_clken", 64'(clken), 64'(1));
        checkOutput("lat_raddr", 64'(raddr), 64'(0));
        checkOutput("lat_tvalid_early", 64'(tvalid), 64'(0));
        @(negedge clk);
        checkOutput("lat_tvalid", 64'(tvalid), 64'(1));
        waitDone("ramp_done", 100);
        @(negedge clk);
        checkOutput("post_axis_tx", 64'(axis_tx), 64'(0));
        checkOutput("post_busy", 64'(busy), 64'(0));

        $display("[TB] random backpressure frames");
        ready_mode = 1;
        for (int f = 0; f < 3; f++) begin
            fillRandom();
            applyStimulus(1);
            waitDone("rand_done", 400);
        end

        $display("[TB] last beat held through drain");
        ready_mode = 2;
        hold_cnt = 0;
        fillRandom();
        applyStimulus(1);
        waitDone("drain_done", 200);
        checkOutput("drain_hold", 64'(hold_cnt), 64'(5));

        $display("[TB] reset mid-frame at beat 7");
        ready_mode = 0;
        fillRamp();
        b0 = beats_seen;
        dc0 = done_count;
        applyStimulus(1);
        waitBeats(b0 + 7, 100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("abort_tvalid", 64'(tvalid), 64'(0));
        checkOutput("abort_axis_tx", 64'(axis_tx), 64'(0));
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_done", 64'(done), 64'(0));
        checkOutput("abort_no_done", 64'(done_count - dc0), 64'(0));
        applyStimulus(1);
        waitDone("replay_done", 100);

        $display("[TB] ignored starts and back-to-back frame");
        fillRandom();
        dc0 = done_count;
        b0 = beats_seen;
        applyStimulus(1);
        waitBeats(b0 + 5, 100);
        pulseStartNow(0);
        begin
            int n = 0;
            while (!(tvalid && tlast) && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            checkOutput("last_seen", 64'(tvalid && tlast), 64'(1));
        end
        pulseStartNow(0);
        @(posedge clk);
        #1;
        pulseStartNow(1);
        waitDone("b2b_done", 100);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("b2b_done_total", 64'(done_count - dc0), 64'(2));
        checkOutput("b2b_idle", 64'(busy), 64'(0));

        checkOutput("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
